// File: rtl/seg_result_sched_pkg.sv
// Shared types and constants for the recognition-result display path.
package seg_ctrl_pkg;
  typedef enum logic {IDLE, SHOW} state_t;

  // {digit, conf1, conf2, conf3}, one nibble each
  typedef logic [15:0] result_t;

  localparam logic [3:0] IDLE_CODE_DEF = 4'ha;
endpackage

// File: rtl/seg_result_sched_if.sv
// Result handshake from the recognition engine into the display scheduler.
// valid/ready: a result transfers on a rising edge where in_valid && in_ready;
// the producer keeps data stable while in_valid is high and not yet accepted.
interface seg_result_sched_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_num;
  logic [3:0] in_p1;
  logic [3:0] in_p2;
  logic [3:0] in_p3;

  modport master (output in_valid, in_num, in_p1, in_p2, in_p3, input in_ready);
  modport slave  (input in_valid, in_num, in_p1, in_p2, in_p3, output in_ready);
endinterface

// File: rtl/seg_result_sched_fifo.sv
// Small result buffer: combinational head, level counter separates full/empty.
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (level == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/seg_result_sched.sv
// Holds each buffered recognition result on the display for HOLD_CYCLES clocks.
module seg_result_sched
  import seg_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [3:0]  IDLE_CODE   = IDLE_CODE_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  seg_result_sched_if.slave             res,
  output logic [3:0]                    num,
  output logic [3:0]                    point_num1,
  output logic [3:0]                    point_num2,
  output logic [3:0]                    point_num3,
  output logic                          disp_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output state_t                        state_dbg
);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] hold_cnt;
  result_t       head;
  result_t       wr_data;
  logic          full;
  logic          wr_en;
  logic          pop;
  logic          expire;
  logic          empty;

  assign res.in_ready = !full && !clear;
  assign wr_data      = {res.in_num, res.in_p1, res.in_p2, res.in_p3};
  assign wr_en        = res.in_valid && res.in_ready;
  assign empty        = (fifo_level == '0);
  assign expire       = (state == SHOW) && (hold_cnt == HOLD_LAST);
  // IDLE pops as soon as anything is buffered; SHOW only at hold expiry
  assign pop          = !clear && !empty && ((state == IDLE) || expire);

  assign disp_busy = (state == SHOW);
  assign state_dbg = state;

  result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .level   (fifo_level),
    .full    (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      num        <= IDLE_CODE;
      point_num1 <= IDLE_CODE;
      point_num2 <= IDLE_CODE;
      point_num3 <= IDLE_CODE;
    end else if (clear) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      num        <= IDLE_CODE;
      point_num1 <= IDLE_CODE;
      point_num2 <= IDLE_CODE;
      point_num3 <= IDLE_CODE;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {num, point_num1, point_num2, point_num3} <= head;
            hold_cnt <= '0;
            state    <= SHOW;
          end
        end
        SHOW: begin
          if (pop) begin
            {num, point_num1, point_num2, point_num3} <= head;
            hold_cnt <= '0;
          end else if (expire) begin
            // last result stays on the display while idle
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_result_sched.sv
// Randomised bench for seg_result_sched against a time-left/queue display model.
module tb_seg_result_sched;
  import seg_ctrl_pkg::*;

  localparam int HOLD  = 8;
  localparam int DEPTH = 4;
  localparam logic [3:0] IC = 4'ha;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic [3:0] num, point_num1, point_num2, point_num3;
  logic disp_busy;
  logic [2:0] fifo_level;
  state_t state_dbg;

  seg_result_sched_if rif ();

  seg_result_sched #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(DEPTH), .IDLE_CODE(IC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .res        (rif.slave),
    .num        (num),
    .point_num1 (point_num1),
    .point_num2 (point_num2),
    .point_num3 (point_num3),
    .disp_busy  (disp_busy),
    .fifo_level (fifo_level),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // model: buffered results, what is on the display, cycles it has left
  logic [15:0] exp_q[$];
  logic [15:0] m_disp;
  int          m_remain;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_disp   = {4{IC}};
    m_remain = 0;
  endtask

  task automatic model_edge(input logic v, input logic [15:0] d, input logic c);
    logic acc;
    logic do_pop;
    if (c) begin
      model_reset();
    end else begin
      acc    = v && (exp_q.size() < DEPTH);
      do_pop = (m_remain <= 1) && (exp_q.size() > 0);
      if (do_pop) begin
        m_disp   = exp_q.pop_front();
        m_remain = HOLD;
      end else if (m_remain > 0) begin
        m_remain--;
      end
      if (acc) exp_q.push_back(d);
    end
  endtask

  task automatic check_all();
    chk("num",        32'(num),        32'(m_disp[15:12]));
    chk("p1",         32'(point_num1), 32'(m_disp[11:8]));
    chk("p2",         32'(point_num2), 32'(m_disp[7:4]));
    chk("p3",         32'(point_num3), 32'(m_disp[3:0]));
    chk("disp_busy",  32'(disp_busy),  32'(m_remain > 0));
    chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("in_ready",   32'(rif.in_ready), 32'((exp_q.size() < DEPTH) && !clear));
  endtask

  // drive at negedge, compare just after, then let the model take the edge
  task automatic step(input logic v, input logic [15:0] d, input logic c);
    @(negedge clk);
    rif.in_valid = v;
    {rif.in_num, rif.in_p1, rif.in_p2, rif.in_p3} = d;
    clear = c;
    #1 check_all();
    @(posedge clk);
    model_edge(v, d, c);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] burst [5];
    int idx;
    int guard;
    int lvl;

    rst_n = 1'b0;
    clear = 1'b0;
    rif.in_valid = 1'b0;
    {rif.in_num, rif.in_p1, rif.in_p2, rif.in_p3} = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_num",   32'(num), 32'h a);
    chk("rst_p3",    32'(point_num3), 32'h a);
    chk("rst_ready", 32'(rif.in_ready), 32'h1);
    chk("rst_busy",  32'(disp_busy), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    rst_n = 1'b1;
    idle_steps(20);
    chk("idle_num",  32'(num), 32'h a);

    // single result: written at edge k, shown from edge k+1 for 8 cycles
    step(1'b1, 16'h7952, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    #2;
    chk("single_num", 32'(num), 32'h7);
    chk("single_p",   32'({point_num1, point_num2, point_num3}), 32'h952);
    chk("single_busy_on", 32'(disp_busy), 32'h1);
    idle_steps(7);
    #2 chk("single_busy_last", 32'(disp_busy), 32'h1);
    idle_steps(1);
    #2;
    chk("single_busy_off", 32'(disp_busy), 32'h0);
    chk("single_keep", 32'(num), 32'h7);
    idle_steps(3);

    // burst of 5 behind a result already on display
    step(1'b1, 16'h1111, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) burst[i] = 16'(16'h2000 + i * 16'h0123);
    idx = 0;
    guard = 0;
    while (idx < 5 && guard < 100) begin
      logic acc;
      acc = exp_q.size() < DEPTH;
      step(1'b1, burst[idx], 1'b0);
      if (acc) idx++;
      guard++;
      if (idx == 4 && acc) begin
        #2;
        chk("burst_full_level", 32'(fifo_level), 32'h4);
        chk("burst_ready_low",  32'(rif.in_ready), 32'h0);
      end
    end
    chk("burst_done", 32'(idx), 32'h5);
    idle_steps(50);

    // write landing on a hold expiry keeps the level
    step(1'b1, 16'h3001, 1'b0);
    step(1'b1, 16'h3002, 1'b0);
    step(1'b1, 16'h3003, 1'b0);
    guard = 0;
    while (m_remain != 1 && guard < 50) begin
      step(1'b0, 16'h0, 1'b0);
      guard++;
    end
    chk("expiry_reached", 32'(m_remain), 32'h1);
    lvl = exp_q.size();
    step(1'b1, 16'h3004, 1'b0);
    #2;
    chk("expiry_level_same", 32'(fifo_level), 32'(lvl));
    chk("expiry_level_lit",  32'(fifo_level), 32'h2);
    idle_steps(40);

    // clear mid-hold with two buffered, data in that cycle dropped
    step(1'b1, 16'h4001, 1'b0);
    step(1'b1, 16'h4002, 1'b0);
    step(1'b1, 16'h4003, 1'b0);
    idle_steps(2);
    step(1'b1, 16'h4999, 1'b1);
    #2;
    chk("clear_num",   32'(num), 32'h a);
    chk("clear_p",     32'({point_num1, point_num2, point_num3}), 32'h aaa);
    chk("clear_level", 32'(fifo_level), 32'h0);
    chk("clear_busy",  32'(disp_busy), 32'h0);
    idle_steps(12);

    // async reset mid-hold
    step(1'b1, 16'h5001, 1'b0);
    step(1'b1, 16'h5002, 1'b0);
    idle_steps(3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_num",   32'(num), 32'h a);
    chk("arst_p1",    32'(point_num1), 32'h a);
    chk("arst_level", 32'(fifo_level), 32'h0);
    chk("arst_busy",  32'(disp_busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_steps(12);

    // randomised traffic
    for (int i = 0; i < 800; i++) begin
      logic v;
      logic c;
      v = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 2);
      step(v, 16'($urandom), c);
    end
    idle_steps(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_result_sched.md
# seg_result_sched

Display scheduler between the digit-recognition engine and the six-digit segment display driver. It accepts recognition results (class digit plus three confidence digits) through a valid/ready handshake and buffers them in a small FIFO. It presents each result on the display outputs for a fixed hold time, so that back-to-back results remain human-readable. Its outputs feed the display driver's `num` and `point_num1..3` inputs directly.

## Interface
- `HOLD_CYCLES`, 50_000_000: clock cycles each result is held; 1 s at 50 MHz; must be ≥ 2.
- `FIFO_DEPTH`, 4: result buffer depth; power of two, ≥ 2.
- `IDLE_CODE`, 4'ha: nibble driven on all four display outputs after reset or clear.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush; one-cycle pulse or level.
- `in_valid`  in  1  result offered.
- `in_ready`  out  1  result can be accepted.
- `in_num`  in  4  recognised digit.
- `in_p1`, `in_p2`, `in_p3`  in  4 each  confidence digits.
- `num`  out  4  displayed digit.
- `point_num1`, `point_num2`, `point_num3`  out  4 each  displayed confidence digits.
- `disp_busy`  out  1  a hold period is running.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries buffered.

## Operation
- Each FIFO entry is 16 bits: {in_num, in_p1, in_p2, in_p3}.
- A write occurs at a rising edge with `in_valid && in_ready`.
- `in_ready = !full && !clear`. There is no write/pop bypass: when the FIFO is full, `in_ready` stays low even in a cycle where a pop occurs.
- FSM states are IDLE and SHOW.
- IDLE:
  - If `fifo_level != 0`: pop the head into the output registers, reset `hold_cnt` to 0, go to SHOW.
  - Otherwise hold the outputs unchanged.
- SHOW: `hold_cnt` increments every cycle. When `hold_cnt == HOLD_CYCLES-1`:
  - FIFO non-empty: pop the next entry, reload the outputs, set `hold_cnt` to 0, stay in SHOW.
  - FIFO empty: go to IDLE. The outputs keep the last result; IDLE does not blank the display.
- Write and pop in the same cycle leave `fifo_level` unchanged, with both pointers advancing.
- `clear` has priority over all other activity and takes effect at the next edge:
  - FIFO emptied and both pointers set to 0.
  - All four outputs set to `IDLE_CODE`.
  - State set to IDLE and `hold_cnt` set to 0.
  - Data offered in a clear cycle is dropped.
- Pointers wrap modulo `FIFO_DEPTH`. The level counter distinguishes full from empty.
- `hold_cnt` width is $clog2(HOLD_CYCLES). It never exceeds `HOLD_CYCLES-1`.

## Timing
- Reset values:
  - `num`, `point_num1..3` = `IDLE_CODE`.
  - `in_ready` = 1.
  - `disp_busy` = 0.
  - `fifo_level` = 0.
  - State IDLE, `hold_cnt` 0, pointers 0.
- Reset asserted mid-hold aborts immediately (asynchronous) and discards buffered results.
- Latency: write at edge k into an empty FIFO while IDLE → pop at edge k+1 → new outputs and `disp_busy = 1` visible after edge k+1.
- Each displayed result persists for exactly `HOLD_CYCLES` cycles before the next one appears, when the next is buffered.
- After the final hold expires with the FIFO empty, `disp_busy` falls after that edge.
- All outputs are registered. `in_ready` is combinational from the level and `clear` only.
- Throughput is one result per `HOLD_CYCLES`. Writes can burst up to `FIFO_DEPTH` back-to-back.

## Structure
- Shared package `seg_ctrl_pkg` holds:
  - state enum {IDLE, SHOW};
  - the 16-bit result entry typedef;
  - the `IDLE_CODE` default constant, shared with the display path.
- Sub-module `result_fifo`, parameterised by depth and width:
  - combinational head read;
  - write/pop/flush ports;
  - level and full outputs.
- The FSM, hold counter and output registers stay in the top level.

## Test plan
All scenarios use `HOLD_CYCLES=8`, `FIFO_DEPTH=4`.
- Reset with no writes → outputs 4'ha, `in_ready=1`, `disp_busy=0`; stable for 20 cycles.
- Single write {7,9,5,2} at edge k → `num=7`, `p1..3=9,5,2` from edge k+1; `disp_busy` high for 8 cycles; outputs still 7/9/5/2 afterwards.
- Burst of 5 writes with `in_valid` held high → 4 accepted at consecutive edges; `in_ready` low until the first pop; 5th accepted only after `in_ready` returns high. Results shown in order, each for exactly 8 cycles.
- Write arriving on the same edge as a hold expiry with the FIFO non-empty → level unchanged; display order preserved.
- `clear` mid-hold with 2 entries buffered → next edge gives outputs 4'ha, `fifo_level=0`, `disp_busy=0`. Data offered in the same cycle is dropped.
- `rst_n` pulse low mid-hold → outputs 4'ha immediately, without waiting for `clk`; FIFO empty afterwards.
